alu_8_bit_core: RTL and testbench
=================================

// Module: alu_8_bit_core
// PURPOSE
//  Clocked 8-bit ALU that responds to the opcode/operand stimulus interface.
//  - Accepts one operation per in_valid strobe.
//  - Returns a registered result (alu_out, carry) with a one-cycle out_valid pulse.
//  - Logic/add ops take one cycle; MUL runs on an iterative shift-add engine.
//  - Standalone datapath unit, driven directly by the test stimulus or a future sequencer.
// PARAMETERS
//  DATA_WIDTH    8   operand/result width; all arithmetic rules below are written for 8
//  OPCODE_WIDTH  8   opcode bus width; only codes 0..10 are legal
// PORTS
//  CLK        in   1   system clock, rising edge
//  RESET      in   1   synchronous reset, active-low
//  in_valid   in   1   operation request, sampled on a CLK edge
//  opcode     in   8   operation select
//  operand_a  in   8   operand A
//  operand_b  in   8   operand B
//  busy       out  1   high while a MUL is in progress; requests are ignored
//  out_valid  out  1   one-cycle pulse: alu_out/carry/illegal updated
//  alu_out    out  8   result, held until the next result
//  carry      out  1   carry/borrow/shift-out flag, held with alu_out
//  illegal    out  1   last accepted opcode was undefined, held with alu_out
// BEHAVIOUR
//  Reset: on a CLK edge with RESET=0, busy, out_valid, alu_out, carry, illegal and the
//   MUL counter all go to 0. A MUL in flight is aborted and produces no out_valid.
//  Accept: an edge with RESET=1, in_valid=1 and busy=0 captures opcode and operands.
//   in_valid while busy=1 is dropped: no queueing, no error.
//  FSM IDLE->EXEC(MUL only)->IDLE:
//   - Single-cycle op accepted at edge E: result and out_valid=1 are visible after E.
//   - MUL accepted at E: busy=1 after E. One add/shift step per edge E+1..E+8.
//     Result, out_valid=1 and busy=0 are all visible after E+8.
//   - Back-to-back: a new op may be accepted on the edge after out_valid rises.
//  out_valid is exactly one cycle wide. alu_out/carry/illegal change only with it.
//  Ops (result is mod 256):
//   0 ADD  a+b;  carry = bit 8 of the 9-bit sum
//   1 SUB  a-b;  carry = borrow (a<b)
//   2 AND, 3 OR, 4 XOR  bitwise;  carry = 0
//   5 NOT  ~a;   carry = 0
//   6 SHL  a<<1; carry = a[7]
//   7 SHR  a>>1 logical; carry = a[0]
//   8 INC  a+1;  carry = (a==8'hFF)
//   9 DEC  a-1;  carry = (a==0)
//   10 MUL 16-bit product; alu_out = low byte, carry = |high byte
//  Opcodes 11..255: alu_out=0, carry=0, illegal=1, single-cycle, out_valid pulses.
//   Any legal op clears illegal.
//  operand_b is ignored for ops 5..9.
//  Inputs are not re-sampled during EXEC. Operand changes mid-MUL have no effect.
// CONFIGURATION
//  ALU_MUL_EN defined:
//   - Opcode 10 uses the 8-cycle shift-add engine as described above.
//  ALU_MUL_EN undefined:
//   - No multiplier or EXEC state is built; busy is tied to 0.
//   - Opcode 10 is treated as illegal (alu_out=0, carry=0, illegal=1, 1-cycle).
// TESTING
//  T1 ADD a=200 b=100 -> after 1 edge: alu_out=44, carry=1, out_valid pulse of 1 cycle
//  T2 SUB a=5 b=10 -> 251, carry=1
//     SHL a=8'h81 -> 8'h02, carry=1
//     DEC a=0 -> 255, carry=1
//  T3 MUL a=15 b=17 -> busy=1 for 8 cycles, then alu_out=255, carry=0;
//     MUL a=16 b=16 -> alu_out=0, carry=1
//  T4 During MUL, in_valid with ADD 1+1 -> ignored; only the MUL result appears,
//     with exactly one out_valid
//  T5 RESET=0 at cycle 4 of a MUL -> after that edge, all outputs 0 and busy=0;
//     no late out_valid; the next ADD 3+4 returns 7
//  T6 opcode=8'hFF -> alu_out=0, carry=0, illegal=1; next AND 8'hF0&8'h3C -> 8'h30, illegal=0;
//     rebuild without ALU_MUL_EN: opcode 10 -> illegal=1 after 1 cycle

Source files
------------

// File: rtl/alu_8_bit_core_if.sv
// Operation request / result bus for alu_8_bit_core.
// master: stimulus side (drives in_valid/opcode/operands, observes results)
// slave : ALU side (observes requests, drives busy/out_valid/alu_out/carry/illegal)
interface alu_8_bit_core_if #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 8
);
  logic                    in_valid;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0]   operand_a;
  logic [DATA_WIDTH-1:0]   operand_b;
  logic                    busy;
  logic                    out_valid;
  logic [DATA_WIDTH-1:0]   alu_out;
  logic                    carry;
  logic                    illegal;

  modport master (
    output in_valid, opcode, operand_a, operand_b,
    input  busy, out_valid, alu_out, carry, illegal
  );

  modport slave (
    input  in_valid, opcode, operand_a, operand_b,
    output busy, out_valid, alu_out, carry, illegal
  );
endinterface

// File: rtl/alu_8_bit_core.sv
// Clocked 8-bit ALU: one operation per accepted in_valid, registered result
// with a one-cycle out_valid pulse. Opcode 10 (MUL) uses an iterative
// shift-add engine when the ALU_MUL_EN macro is defined; otherwise it is
// treated as an illegal opcode and busy is tied low.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - synchronous reset, active-low
//   bus   - alu_8_bit_core_if.slave: in_valid/opcode/operand_a/operand_b in,
//           busy/out_valid/alu_out/carry/illegal out
module alu_8_bit_core #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned OPCODE_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  alu_8_bit_core_if.slave   bus
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_INC = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_DEC = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(10);

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] alu_out_q;
  logic                  carry_q;
  logic                  illegal_q;

  // Single-cycle result for the opcode currently on the bus
  logic [DATA_WIDTH:0]   sum_c;
  logic [DATA_WIDTH-1:0] res_c;
  logic                  cry_c;
  logic                  ill_c;
`ifdef ALU_MUL_EN
  logic                  is_mul_c;
`endif

  always_comb begin
    sum_c = '0;
    res_c = '0;
    cry_c = 1'b0;
    ill_c = 1'b0;
`ifdef ALU_MUL_EN
    is_mul_c = 1'b0;
`endif
    case (bus.opcode)
      OP_ADD: begin
        sum_c = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
        res_c = sum_c[DATA_WIDTH-1:0];
        cry_c = sum_c[DATA_WIDTH];
      end
      OP_SUB: begin
        // bit W of the extended difference is the borrow
        sum_c = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
        res_c = sum_c[DATA_WIDTH-1:0];
        cry_c = sum_c[DATA_WIDTH];
      end
      OP_AND: res_c = bus.operand_a & bus.operand_b;
      OP_OR:  res_c = bus.operand_a | bus.operand_b;
      OP_XOR: res_c = bus.operand_a ^ bus.operand_b;
      OP_NOT: res_c = ~bus.operand_a;
      OP_SHL: begin
        res_c = {bus.operand_a[DATA_WIDTH-2:0], 1'b0};
        cry_c = bus.operand_a[DATA_WIDTH-1];
      end
      OP_SHR: begin
        res_c = {1'b0, bus.operand_a[DATA_WIDTH-1:1]};
        cry_c = bus.operand_a[0];
      end
      OP_INC: begin
        sum_c = {1'b0, bus.operand_a} + (DATA_WIDTH+1)'(1);
        res_c = sum_c[DATA_WIDTH-1:0];
        cry_c = sum_c[DATA_WIDTH];
      end
      OP_DEC: begin
        sum_c = {1'b0, bus.operand_a} - (DATA_WIDTH+1)'(1);
        res_c = sum_c[DATA_WIDTH-1:0];
        cry_c = sum_c[DATA_WIDTH];
      end
`ifdef ALU_MUL_EN
      OP_MUL: is_mul_c = 1'b1;
`else
      OP_MUL: ill_c = 1'b1;
`endif
      default: ill_c = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [PROD_W-1:0]     acc_q;
  logic [PROD_W-1:0]     mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic [PROD_W-1:0]     acc_d;

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set
  assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Control FSM, MUL engine and result registers
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (is_mul_c) begin
              // operands are latched here; the bus is not looked at again until done
              state_q  <= S_EXEC;
              busy_q   <= 1'b1;
              cnt_q    <= '0;
              acc_q    <= '0;
              mcand_q  <= PROD_W'(bus.operand_a);
              mplier_q <= bus.operand_b;
            end else begin
              out_valid_q <= 1'b1;
              alu_out_q   <= res_c;
              carry_q     <= cry_c;
              illegal_q   <= ill_c;
            end
          end
        end
        S_EXEC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b1;
            alu_out_q   <= acc_d[DATA_WIDTH-1:0];
            carry_q     <= |acc_d[PROD_W-1:DATA_WIDTH];
            illegal_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
`else
  // Result registers; every accepted op completes in one cycle
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        alu_out_q <= res_c;
        carry_q   <= cry_c;
        illegal_q <= ill_c;
      end
    end
  end

  assign bus.busy = 1'b0;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.alu_out   = alu_out_q;
  assign bus.carry     = carry_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_8_bit_core.sv
// Self-checking bench for alu_8_bit_core: vector table of single-cycle ops
// applied back-to-back through a scoreboard queue, plus directed sequences
// for reset, pulse width and (when ALU_MUL_EN is defined) the MUL engine.
module tb_alu_8_bit_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_8_bit_core_if bus ();

  alu_8_bit_core dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       c;
    logic       ill;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       c;
    logic       ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   n_seen = 0;
  int   n_mark = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_vec(input string name, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] out, input logic c,
                         input logic ill);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.out = out; v.c = c; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input string name, input logic [7:0] out, input logic c,
                          input logic ill);
    exp_t e;
    e.name = name; e.out = out; e.c = c; e.ill = ill;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.operand_a = a;
    bus.operand_b = b;
  endtask

  // Wait (bounded) for every queued expectation to be consumed by the monitor
  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (sbq.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    chk({name, "_pending"}, 16'(sbq.size()), 16'd0);
    sbq.delete();
  endtask

  // Single op: drive one cycle, expect one result
  task automatic one_op(input string name, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] out, input logic c,
                        input logic ill);
    @(negedge clk);
    drive(op, a, b);
    push_exp(name, out, c, ill);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain(name, 20);
  endtask

  // Scoreboard monitor: every out_valid pulse consumes one expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1) begin
      n_seen++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid alu_out=%0h carry=%0b required=no_pulse",
                 bus.alu_out, bus.carry);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_out"}, 16'(bus.alu_out), 16'(mon_e.out));
        chk({mon_e.name, "_carry"}, 16'(bus.carry), 16'(mon_e.c));
        chk({mon_e.name, "_illegal"}, 16'(bus.illegal), 16'(mon_e.ill));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    add_vec("t1_add_200_100", 8'd0,  8'd200, 8'd100, 8'd44,  1'b1, 1'b0);
    add_vec("add_0_0",        8'd0,  8'd0,   8'd0,   8'd0,   1'b0, 1'b0);
    add_vec("sub_5_10",       8'd1,  8'd5,   8'd10,  8'd251, 1'b1, 1'b0);
    add_vec("sub_10_5",       8'd1,  8'd10,  8'd5,   8'd5,   1'b0, 1'b0);
    add_vec("sub_equal",      8'd1,  8'd77,  8'd77,  8'd0,   1'b0, 1'b0);
    add_vec("and",            8'd2,  8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0);
    add_vec("or",             8'd3,  8'hF0,  8'h0F,  8'hFF,  1'b0, 1'b0);
    add_vec("xor",            8'd4,  8'hAA,  8'hFF,  8'h55,  1'b0, 1'b0);
    add_vec("not_b_ignored",  8'd5,  8'h0F,  8'h12,  8'hF0,  1'b0, 1'b0);
    add_vec("shl_81",         8'd6,  8'h81,  8'hFF,  8'h02,  1'b1, 1'b0);
    add_vec("shl_40",         8'd6,  8'h40,  8'h00,  8'h80,  1'b0, 1'b0);
    add_vec("shr_81",         8'd7,  8'h81,  8'h00,  8'h40,  1'b1, 1'b0);
    add_vec("shr_fe",         8'd7,  8'hFE,  8'h00,  8'h7F,  1'b0, 1'b0);
    add_vec("inc_ff",         8'd8,  8'hFF,  8'h00,  8'h00,  1'b1, 1'b0);
    add_vec("inc_07",         8'd8,  8'h07,  8'h55,  8'h08,  1'b0, 1'b0);
    add_vec("dec_00",         8'd9,  8'h00,  8'h00,  8'hFF,  1'b1, 1'b0);
    add_vec("dec_01",         8'd9,  8'h01,  8'hAA,  8'h00,  1'b0, 1'b0);
    add_vec("illegal_ff",     8'hFF, 8'h12,  8'h34,  8'h00,  1'b0, 1'b1);
    add_vec("and_clears_ill", 8'd2,  8'hF0,  8'h3C,  8'h30,  1'b0, 1'b0);
    add_vec("illegal_11",     8'd11, 8'hFF,  8'hFF,  8'h00,  1'b0, 1'b1);
    add_vec("add_after_ill",  8'd0,  8'd3,   8'd4,   8'd7,   1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",      16'(bus.busy),      16'd0);
    chk("reset_out_valid", 16'(bus.out_valid), 16'd0);
    chk("reset_alu_out",   16'(bus.alu_out),   16'd0);
    chk("reset_carry",     16'(bus.carry),     16'd0);
    chk("reset_illegal",   16'(bus.illegal),   16'd0);
    rst_n = 1'b1;

    // Table applied back-to-back: one accept per cycle
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      push_exp(vecs[i].name, vecs[i].out, vecs[i].c, vecs[i].ill);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_drain("table", 20);
    @(negedge clk);
    chk("table_pulse_ended", 16'(bus.out_valid), 16'd0);

    // out_valid is one cycle wide and the result is held afterwards
    @(negedge clk);
    drive(8'd0, 8'd200, 8'd100);
    push_exp("pulse_add", 8'd44, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pulse_high", 16'(bus.out_valid), 16'd1);
    @(negedge clk);
    chk("pulse_low",   16'(bus.out_valid), 16'd0);
    chk("held_out",    16'(bus.alu_out),   16'd44);
    chk("held_carry",  16'(bus.carry),     16'd1);
    repeat (3) @(negedge clk);
    chk("held_out_later", 16'(bus.alu_out), 16'd44);
    wait_drain("pulse", 5);

    // Reset clears held result registers
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_alu_out", 16'(bus.alu_out), 16'd0);
    chk("rst2_carry",   16'(bus.carry),   16'd0);
    rst_n = 1'b1;
    one_op("after_rst2_add", 8'd0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);

`ifdef ALU_MUL_EN
    // T3: MUL 15*17, busy for 8 cycles, then result with busy low
    n_mark = n_seen;
    @(negedge clk);
    drive(8'd10, 8'd15, 8'd17);
    push_exp("mul_15_17", 8'd255, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mul_busy_%0d", i), {15'd0, bus.busy}, 16'd1);
      chk($sformatf("mul_no_valid_%0d", i), {15'd0, bus.out_valid}, 16'd0);
      @(negedge clk);
    end
    chk("mul_done_busy",  16'(bus.busy),      16'd0);
    chk("mul_done_valid", 16'(bus.out_valid), 16'd1);
    wait_drain("mul_15_17", 5);
    chk("mul_15_17_pulses", 16'(n_seen - n_mark), 16'd1);

    // T3/T4: MUL 16*16 with a dropped ADD and operand changes mid-flight
    n_mark = n_seen;
    @(negedge clk);
    drive(8'd10, 8'd16, 8'd16);
    push_exp("mul_16_16", 8'd0, 1'b1, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    drive(8'd0, 8'd1, 8'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.operand_a = 8'hFF;
    bus.operand_b = 8'hFF;
    wait_drain("mul_16_16", 20);
    repeat (4) @(negedge clk);
    chk("mul_16_16_pulses", 16'(n_seen - n_mark), 16'd1);

    // Back-to-back: new op accepted on the edge after the MUL result
    @(negedge clk);
    drive(8'd10, 8'd3, 8'd5);
    push_exp("mul_3_5", 8'd15, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && bus.busy === 1'b1) @(negedge clk);
    drive(8'd8, 8'd9, 8'd0);
    push_exp("b2b_inc", 8'd10, 1'b0, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_drain("b2b", 20);

    // T5: reset on the 4th step edge aborts the MUL with no late out_valid
    n_mark = n_seen;
    @(negedge clk);
    drive(8'd10, 8'd15, 8'd17);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy",      16'(bus.busy),      16'd0);
    chk("abort_out_valid", 16'(bus.out_valid), 16'd0);
    chk("abort_alu_out",   16'(bus.alu_out),   16'd0);
    chk("abort_carry",     16'(bus.carry),     16'd0);
    chk("abort_illegal",   16'(bus.illegal),   16'd0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_late_valid", 16'(n_seen - n_mark), 16'd0);
    one_op("abort_then_add", 8'd0, 8'd3, 8'd4, 8'd7, 1'b0, 1'b0);
`else
    // Without the multiplier, opcode 10 is a one-cycle illegal op and busy never rises
    n_mark = n_seen;
    @(negedge clk);
    drive(8'd10, 8'd15, 8'd17);
    push_exp("op10_illegal", 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("op10_busy",  16'(bus.busy),      16'd0);
    chk("op10_valid", 16'(bus.out_valid), 16'd1);
    wait_drain("op10", 5);
    repeat (10) @(negedge clk);
    chk("op10_pulses", 16'(n_seen - n_mark), 16'd1);
    one_op("op10_then_and", 8'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("final_queue_empty", 16'(sbq.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
